// File: rtl/display_pkg.sv
// Shared state encoding and address helpers for the display frame scheduler.
package display_pkg;

  typedef enum logic [1:0] {IDLE, RUN, SWAP_WAIT} state_t;

  function automatic int addr_width(input int n_rows, input int n_columns);
    return 1 + $clog2(n_rows) + $clog2(n_columns);
  endfunction

  // Packs {bank, row, column} into the low bits; callers cast to their address width.
  function automatic logic [31:0] make_addr(input logic bank, input logic [15:0] row,
                                            input logic [15:0] column, input int cw, input int rw);
    return (32'(bank) << (cw + rw)) | (32'(row) << cw) | 32'(column);
  endfunction

endpackage

// File: rtl/display_frame_edge_counter.sv
// Frame-complete edge detector with a wrapping frame counter and a
// saturating per-bank shown-frames counter.
module display_frame_edge_counter
  import display_pkg::*;
#(
  parameter int min_frames = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_frame_complete,
  input  logic        i_clear_shown,
  output logic        o_fc_edge,
  output logic [15:0] o_frame_count,
  output logic [7:0]  o_shown
);

  localparam logic [7:0] MIN_SHOWN = 8'(min_frames);

  logic        r_fc_d;
  logic [15:0] r_frame_count;
  logic [7:0]  r_shown;

  // The driver may hold frame_complete for two cycles; only the rising edge counts.
  assign o_fc_edge     = i_frame_complete && !r_fc_d;
  assign o_frame_count = r_frame_count;
  assign o_shown       = r_shown;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fc_d        <= 1'b0;
      r_frame_count <= '0;
      r_shown       <= '0;
    end else begin
      r_fc_d <= i_frame_complete;
      if (o_fc_edge)
        r_frame_count <= r_frame_count + 16'd1;
      if (i_clear_shown)
        r_shown <= '0;
      else if (o_fc_edge && (r_shown < MIN_SHOWN))
        r_shown <= r_shown + 8'd1;
    end
  end

endmodule

// File: rtl/display_frame_scheduler.sv
// Display driver sequencer: front/back bank ownership, registered read
// addressing, host write forwarding and frame-aligned bank swaps.
module display_frame_scheduler
  import display_pkg::*;
#(
  parameter int segments   = 1,
  parameter int rows       = 8,
  parameter int columns    = 32,
  parameter int bitwidth   = 8,
  parameter int min_frames = 1,
  localparam int RW = $clog2(rows),
  localparam int CW = $clog2(columns),
  localparam int AW = addr_width(rows, columns),
  localparam int PW = bitwidth * 3 * segments
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic          drv_rst,
  input  logic [RW-1:0] drv_row,
  input  logic [CW-1:0] drv_column,
  input  logic          drv_frame_complete,
  output logic [AW-1:0] rd_addr,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [RW-1:0] wr_row,
  input  logic [CW-1:0] wr_column,
  input  logic [PW-1:0] wr_pixel,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [PW-1:0] ram_wdata,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          front_bank,
  output logic [15:0]   frame_count
);

  localparam logic [7:0] MIN_SHOWN = 8'(min_frames);

  state_t        r_state, w_next_state;
  logic          r_front_bank, r_swap_ack, r_ack_d, r_ram_we;
  logic [AW-1:0] r_rd_addr, r_ram_waddr;
  logic [PW-1:0] r_ram_wdata;
  logic          w_fc_edge, w_guard, w_eligible, w_swap_now, w_wr_ready, w_accept;
  logic [7:0]    w_shown;

  display_frame_edge_counter #(.min_frames(min_frames)) u_edge_counter (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_frame_complete (drv_frame_complete),
    .i_clear_shown    (w_swap_now),
    .o_fc_edge        (w_fc_edge),
    .o_frame_count    (frame_count),
    .o_shown          (w_shown)
  );

  // A request still held during the ack and the cycle after must not start a second swap.
  assign w_guard    = r_swap_ack || r_ack_d;
  assign w_eligible = (w_shown >= MIN_SHOWN) || (w_fc_edge && ((w_shown + 8'd1) >= MIN_SHOWN));
  assign w_accept   = wr_valid && w_wr_ready;

  always_comb begin
    w_next_state = r_state;
    w_swap_now   = 1'b0;
    w_wr_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        w_swap_now = swap_req && !w_guard;
        w_wr_ready = !w_swap_now;
        if (enable) w_next_state = RUN;
      end
      RUN: begin
        w_wr_ready = 1'b1;
        if (swap_req && !w_guard && w_eligible) w_next_state = SWAP_WAIT;
      end
      SWAP_WAIT: begin
        if (w_fc_edge) begin
          w_swap_now   = 1'b1;
          w_next_state = RUN;
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (!enable) begin
      w_next_state = IDLE;
      if (r_state == SWAP_WAIT) w_swap_now = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr    <= '0;
      r_ram_we     <= 1'b0;
      r_ram_waddr  <= '0;
      r_ram_wdata  <= '0;
      r_swap_ack   <= 1'b0;
      r_ack_d      <= 1'b0;
      r_front_bank <= 1'b0;
    end else begin
      r_rd_addr <= AW'(make_addr(r_front_bank, 16'(drv_row), 16'(drv_column), CW, RW));
      r_ram_we  <= w_accept;
      if (w_accept) begin
        r_ram_waddr <= AW'(make_addr(!r_front_bank, 16'(wr_row), 16'(wr_column), CW, RW));
        r_ram_wdata <= wr_pixel;
      end
      r_swap_ack <= w_swap_now;
      r_ack_d    <= r_swap_ack;
      if (w_swap_now) r_front_bank <= !r_front_bank;
    end
  end

  assign drv_rst    = (r_state == IDLE);
  assign wr_ready   = rst_n && w_wr_ready;
  assign rd_addr    = r_rd_addr;
  assign ram_we     = r_ram_we;
  assign ram_waddr  = r_ram_waddr;
  assign ram_wdata  = r_ram_wdata;
  assign swap_ack   = r_swap_ack;
  assign front_bank = r_front_bank;

endmodule
